smc_ustep_seq: RTL and testbench
================================

# smc_ustep_seq

Microstep sequencer and Q-bus arbiter for one motor of the stepper motor controller (`smc`). It accepts step commands (count, direction, period) and advances a 64-position electrical phase. On each step it writes sine/cosine duty words into the two `smc` duty registers for that motor's coil pair. It shares the single `smc` Q-bus slave port with a host master; the host always has priority.

## Interface
Parameters:
- `MOTOR`, 0: motor index 0..5; coil A = channel 2·MOTOR, coil B = channel 2·MOTOR+1.
- `DC_BASE`, 7'h20: Q-bus address of duty register channel 0; channel k lives at `DC_BASE + 2k`.

Ports:
- `QCLK` in 1: clock, all logic on rising edge.
- `QRESET` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_dir` in 1: 1 = phase +1 per step, 0 = phase −1.
- `cmd_steps` in 16: number of steps.
- `step_period` in 16: wait cycles per step.
- `cmd_abort` in 1: stop the current command.
- `busy` out 1: high whenever not in IDLE.
- `done` out 1: one-cycle pulse at command completion or abort.
- `phase` out 6: current electrical phase.
- `host_sel` in 1: host Q-bus request.
- `host_write` in 1: host write/read.
- `host_addr` in 7: host address.
- `host_data` in 16: host write data.
- `QSEL` out 1: to `smc` `QSEL`.
- `QWRITE` out 1: to `smc` `QWRITE`.
- `QADDR` out 7: to `smc` `QADDR`.
- `QDATAIN` out 16: write data to `smc` `QDATAIN`.

## Operation
- **Reset values:** all outputs 0 except `cmd_ready` = 1. `phase` = 0. Internal counters = 0. State = IDLE.
- **Command acceptance:**
  - A command is accepted on `cmd_valid & cmd_ready`.
  - `cmd_steps`, `cmd_dir` and `step_period` are latched at acceptance.
  - `step_period` = 0 is treated as 1.
  - `cmd_steps` = 0: no bus writes; `done` pulses the next cycle; return to IDLE.
- **State machine:**
  - IDLE → WAIT on acceptance.
  - WAIT counts P cycles → ADV.
  - ADV: `phase` ± 1, modulo 64 (63+1 = 0, 0−1 = 63) → WR_A.
  - WR_A issues the coil A write → WR_B.
  - WR_B issues the coil B write, then decrements steps_left. If steps_left is now 0 → IDLE with `done`; otherwise → WAIT.
- **Sine table:** quarter-wave, T[0..16] = 0, 25, 50, 74, 98, 120, 142, 162, 180, 197, 212, 225, 236, 244, 250, 254, 255.
- **Magnitude:** for phase p, q = p[5:4], i = p[3:0]. sin(p) = T[i], T[16−i], −T[i], −T[16−i] for q = 0, 1, 2, 3 respectively.
- **Coil values:** coil A = sin(p); coil B = sin((p+16) mod 64).
- **Duty word:** {sign, 7'b0, mag[7:0]}, sign = 1 for negative. Magnitude 0 is always written with sign 0.
- **Arbitration:**
  - If `host_sel` = 1, the host transaction is forwarded and the sequencer holds in WR_A/WR_B (stall).
  - The WAIT count does not stall for host traffic.
  - Host reads (`host_write` = 0) are forwarded with `QWRITE` = 0.
- **Abort:**
  - `cmd_abort` in WAIT or ADV → IDLE with `done`; `phase` is kept as-is, with no partial step.
  - `cmd_abort` in WR_A → completes WR_B first, then IDLE with `done`.
  - `cmd_abort` in IDLE is ignored.
- **Reset mid-operation:** immediate return to reset values; no further bus writes.

## Timing
- **Bus outputs are registered:** a request or FSM write decided in cycle n drives `QSEL`/`QWRITE`/`QADDR`/`QDATAIN` in cycle n+1, for exactly one cycle each.
- **Idle bus:** all Q-bus outputs are 0 when there is no transaction.
- **Step cost:** P+3 cycles without contention; each host-stall cycle adds 1.
- **First write after acceptance (edge 0):**
  - coil A on the Q-bus in cycle P+3.
  - coil B on the Q-bus in cycle P+4.
- **Done timing:** `done` coincides with the cycle coil B appears on the bus. `cmd_ready` returns high in the same cycle.
- **`phase` output** updates the cycle after ADV.

## Configuration
- **`SMC_USEQ_HOLD_OFF_EN` defined:** after the last step or an abort, the FSM enters OFF_A then OFF_B. These write duty 16'h0000 to coil A then coil B under the same arbitration rules. `done` pulses with the OFF_B bus cycle.
- **Undefined:** the coils keep their last duty words (holding torque); `done` timing is as in Timing.

## Test plan
- **Reset:** assert `QRESET` = 0 mid-WAIT → all outputs 0, `cmd_ready` = 1, `phase` = 0, no Q-bus activity after release.
- **Single forward step:** phase 0, steps = 1, dir = 1, period = 4 → cycle 7: `QADDR` = 0x20, `QDATAIN` = 0x0019; cycle 8: 0x22, 0x00FE; `done` in cycle 8; `phase` = 1.
- **Single reverse step with wrap:** phase 0, steps = 1, dir = 0 → `phase` = 63, coil A 0x8019, coil B 0x00FE.
- **Host contention:** `host_sel` = 1, `host_write` = 1, address 0x10, data 0x1234, held 2 cycles starting at the WR_A cycle → host write on the bus for 2 cycles, coil A write delayed 2 cycles, write values unchanged.
- **Abort:** steps = 100, period = 10, abort in the 3rd WAIT → exactly 2 steps written, `phase` = 2, `done` pulse.
- **Hold-off (macro on):** 64 forward steps from phase 0 → `phase` = 0, final coil writes 0x0000 to 0x20 and 0x22, `done` on the second zero write.

Source files
------------

// File: rtl/smc_ustep_seq.sv
// Microstep sequencer and Q-bus arbiter for one smc motor; the host always has bus priority.
// Define SMC_USEQ_HOLD_OFF_EN to zero both coil duty words after each command ends.
module smc_ustep_seq #(
   parameter int unsigned MOTOR   = 0,
   parameter logic [6:0]  DC_BASE = 7'h20,
   localparam int unsigned STEP_W = 16,
   localparam int unsigned PH_W   = 6,
   localparam int unsigned ADDR_W = 7,
   localparam int unsigned DATA_W = 16
) (
   input  logic              QCLK,
   input  logic              QRESET,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_dir,
   input  logic [STEP_W-1:0] cmd_steps,
   input  logic [STEP_W-1:0] step_period,
   input  logic              cmd_abort,
   output logic              busy,
   output logic              done,
   output logic [PH_W-1:0]   phase,
   input  logic              host_sel,
   input  logic              host_write,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_data,
   output logic              QSEL,
   output logic              QWRITE,
   output logic [ADDR_W-1:0] QADDR,
   output logic [DATA_W-1:0] QDATAIN
);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT, S_ADV, S_WR_A, S_WR_B, S_OFF_A, S_OFF_B
   } state_t;

`ifdef SMC_USEQ_HOLD_OFF_EN
   localparam bit HOLD_OFF = 1'b1;
`else
   localparam bit HOLD_OFF = 1'b0;
`endif

   // Coil A is channel 2*MOTOR, coil B the next channel; channels are two addresses apart.
   localparam logic [ADDR_W-1:0] ADDR_A = ADDR_W'(DC_BASE + ADDR_W'(4 * MOTOR));
   localparam logic [ADDR_W-1:0] ADDR_B = ADDR_W'(ADDR_A + ADDR_W'(2));

   state_t              state_q, state_d;
   logic [STEP_W-1:0]   steps_q, steps_d;
   logic [STEP_W-1:0]   period_q, period_d;
   logic [STEP_W-1:0]   wait_q, wait_d;
   logic                dir_q, dir_d;
   logic                abort_q, abort_d;
   logic [PH_W-1:0]     phase_d;
   logic                done_d, finish, fsm_wr;
   logic [ADDR_W-1:0]   wr_addr;
   logic [DATA_W-1:0]   wr_data;
   logic                bus_sel_d, bus_write_d;
   logic [ADDR_W-1:0]   bus_addr_d;
   logic [DATA_W-1:0]   bus_data_d;

   function automatic logic [7:0] qtab(input logic [4:0] i);
      case (i)
         5'd0:    qtab = 8'd0;
         5'd1:    qtab = 8'd25;
         5'd2:    qtab = 8'd50;
         5'd3:    qtab = 8'd74;
         5'd4:    qtab = 8'd98;
         5'd5:    qtab = 8'd120;
         5'd6:    qtab = 8'd142;
         5'd7:    qtab = 8'd162;
         5'd8:    qtab = 8'd180;
         5'd9:    qtab = 8'd197;
         5'd10:   qtab = 8'd212;
         5'd11:   qtab = 8'd225;
         5'd12:   qtab = 8'd236;
         5'd13:   qtab = 8'd244;
         5'd14:   qtab = 8'd250;
         5'd15:   qtab = 8'd254;
         default: qtab = 8'd255;
      endcase
   endfunction

   // Sign-magnitude duty word; odd quadrants mirror the table, upper half is negative.
   function automatic logic [DATA_W-1:0] duty(input logic [PH_W-1:0] p);
      logic [4:0] idx;
      logic [7:0] mag;
      idx  = p[4] ? (5'd16 - 5'(p[3:0])) : 5'(p[3:0]);
      mag  = qtab(idx);
      duty = {(p[5] && (mag != 8'd0)), 7'd0, mag};
   endfunction

   always_comb begin
      state_d  = state_q;
      steps_d  = steps_q;
      period_d = period_q;
      wait_d   = wait_q;
      dir_d    = dir_q;
      abort_d  = abort_q;
      phase_d  = phase;
      done_d   = 1'b0;
      finish   = 1'b0;
      fsm_wr   = 1'b0;
      wr_addr  = ADDR_A;
      wr_data  = '0;
      case (state_q)
         S_IDLE: if (cmd_valid) begin
            dir_d    = cmd_dir;
            steps_d  = cmd_steps;
            period_d = (step_period == '0) ? STEP_W'(1) : step_period;
            wait_d   = '0;
            abort_d  = 1'b0;
            if (cmd_steps == '0) done_d = 1'b1;
            else                 state_d = S_WAIT;
         end
         S_WAIT: begin
            if (cmd_abort) finish = 1'b1;
            else if (wait_q == period_q - STEP_W'(1)) begin
               wait_d  = '0;
               state_d = S_ADV;
            end else wait_d = wait_q + STEP_W'(1);
         end
         S_ADV: begin
            if (cmd_abort) finish = 1'b1;
            else begin
               phase_d = dir_q ? (phase + PH_W'(1)) : (phase - PH_W'(1));
               state_d = S_WR_A;
            end
         end
         S_WR_A: begin
            if (cmd_abort) abort_d = 1'b1;
            if (!host_sel) begin
               fsm_wr  = 1'b1;
               wr_data = duty(phase);
               state_d = S_WR_B;
            end
         end
         S_WR_B: if (!host_sel) begin
            fsm_wr  = 1'b1;
            wr_addr = ADDR_B;
            wr_data = duty(PH_W'(phase + PH_W'(16)));
            steps_d = steps_q - STEP_W'(1);
            if ((steps_d == '0) || abort_q || cmd_abort) finish = 1'b1;
            else state_d = S_WAIT;
         end
         S_OFF_A: if (!host_sel) begin
            fsm_wr  = 1'b1;
            state_d = S_OFF_B;
         end
         S_OFF_B: if (!host_sel) begin
            fsm_wr  = 1'b1;
            wr_addr = ADDR_B;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (finish) begin
         abort_d = 1'b0;
         if (HOLD_OFF) state_d = S_OFF_A;
         else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
         end
      end
      bus_sel_d   = host_sel | fsm_wr;
      bus_write_d = host_sel ? host_write : fsm_wr;
      bus_addr_d  = host_sel ? host_addr : (fsm_wr ? wr_addr : '0);
      bus_data_d  = host_sel ? host_data : (fsm_wr ? wr_data : '0);
   end

   always_ff @(posedge QCLK or negedge QRESET) begin
      if (!QRESET) begin
         state_q   <= S_IDLE;
         steps_q   <= '0;
         period_q  <= '0;
         wait_q    <= '0;
         dir_q     <= 1'b0;
         abort_q   <= 1'b0;
         phase     <= '0;
         done      <= 1'b0;
         cmd_ready <= 1'b1;
         busy      <= 1'b0;
         QSEL      <= 1'b0;
         QWRITE    <= 1'b0;
         QADDR     <= '0;
         QDATAIN   <= '0;
      end else begin
         state_q   <= state_d;
         steps_q   <= steps_d;
         period_q  <= period_d;
         wait_q    <= wait_d;
         dir_q     <= dir_d;
         abort_q   <= abort_d;
         phase     <= phase_d;
         done      <= done_d;
         cmd_ready <= (state_d == S_IDLE);
         busy      <= (state_d != S_IDLE);
         QSEL      <= bus_sel_d;
         QWRITE    <= bus_write_d;
         QADDR     <= bus_addr_d;
         QDATAIN   <= bus_data_d;
      end
   end

endmodule

// File: tb/tb_smc_ustep_seq.sv
// Bench for smc_ustep_seq: bus monitor plus a trigonometric reference model of the step sequence.
// Honours SMC_USEQ_HOLD_OFF_EN when the design is built with it.
`timescale 1ns/1ps
module tb_smc_ustep_seq;

   typedef struct packed {
      logic [31:0] cyc;
      logic        wr;
      logic [6:0]  addr;
      logic [15:0] data;
   } tx_t;

`ifdef SMC_USEQ_HOLD_OFF_EN
   localparam bit HOLD = 1'b1;
`else
   localparam bit HOLD = 1'b0;
`endif

   logic        QCLK = 1'b0;
   logic        QRESET = 1'b0;
   logic        cmd_valid = 1'b0, cmd_dir = 1'b0, cmd_abort = 1'b0;
   logic [15:0] cmd_steps = '0, step_period = '0;
   logic        host_sel = 1'b0, host_write = 1'b0;
   logic [6:0]  host_addr = '0;
   logic [15:0] host_data = '0;
   logic        cmd_ready, busy, done, QSEL, QWRITE;
   logic [5:0]  phase;
   logic [6:0]  QADDR;
   logic [15:0] QDATAIN;

   smc_ustep_seq #(.MOTOR(0), .DC_BASE(7'h20)) dut (
      .QCLK(QCLK), .QRESET(QRESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .step_period(step_period),
      .cmd_abort(cmd_abort), .busy(busy), .done(done), .phase(phase),
      .host_sel(host_sel), .host_write(host_write), .host_addr(host_addr),
      .host_data(host_data), .QSEL(QSEL), .QWRITE(QWRITE), .QADDR(QADDR),
      .QDATAIN(QDATAIN)
   );

   always #5 QCLK = ~QCLK;

   int   cyc = 0;
   int   tests = 0, fails = 0;
   int   mphase = 0;
   int   rdy_err = 0;
   tx_t  mon_q[$], exp_q[$];
   int   done_q[$];

   always @(posedge QCLK) cyc <= cyc + 1;

   // Every bus cycle and done pulse, stamped with the index of the edge that produced it.
   always @(negedge QCLK) begin
      tx_t t;
      if (QSEL) begin
         t.cyc = 32'(cyc); t.wr = QWRITE; t.addr = QADDR; t.data = QDATAIN;
         mon_q.push_back(t);
      end
      if (done) begin
         done_q.push_back(cyc);
         if (!cmd_ready) rdy_err++;
      end
   end

   function automatic logic [15:0] ref_duty(input int p);
      real s;
      int  mag;
      s   = 255.0 * $sin(2.0 * 3.14159265358979 * real'(p) / 64.0);
      mag = $rtoi(((s < 0.0) ? -s : s) + 0.5);
      if (mag == 0) return 16'h0000;
      return (s < 0.0) ? (16'h8000 | 16'(mag)) : 16'(mag);
   endfunction

   // Appends the coil writes of n steps; returns the edge of the last coil B write.
   function automatic int build_steps(input int acc, input int n, input int dir, input int period);
      tx_t t;
      int  s, x;
      s = ((period == 0) ? 1 : period) + 3;
      x = acc;
      for (int k = 1; k <= n; k++) begin
         mphase = (mphase + (dir != 0 ? 1 : 63)) % 64;
         t.wr = 1'b1;
         t.cyc = 32'(acc + k * s - 1); t.addr = 7'h20; t.data = ref_duty(mphase);
         exp_q.push_back(t);
         t.cyc = 32'(acc + k * s); t.addr = 7'h22; t.data = ref_duty((mphase + 16) % 64);
         exp_q.push_back(t);
         x = acc + k * s;
      end
      return x;
   endfunction

   function automatic int add_end(input int base, input bit active);
      tx_t t;
      if (!(HOLD && active)) return base;
      t.wr = 1'b1; t.data = 16'h0000;
      t.cyc = 32'(base + 1); t.addr = 7'h20; exp_q.push_back(t);
      t.cyc = 32'(base + 2); t.addr = 7'h22; exp_q.push_back(t);
      return base + 2;
   endfunction

   task automatic clear_q();
      mon_q.delete(); exp_q.delete(); done_q.delete();
   endtask

   task automatic do_reset();
      @(negedge QCLK); QRESET = 1'b0;
      @(negedge QCLK); QRESET = 1'b1;
      mphase = 0;
      clear_q();
   endtask

   task automatic run_cmd(input int n, input int dir, input int period, output int acc);
      @(negedge QCLK);
      cmd_valid = 1'b1; cmd_steps = 16'(n); cmd_dir = (dir != 0); step_period = 16'(period);
      acc = cyc + 1;
      @(negedge QCLK);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int maxc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         @(negedge QCLK);
         if (done_q.size() > 0) begin ok = 1'b1; break; end
      end
      repeat (4) @(negedge QCLK);
   endtask

   task automatic test_reset();
      logic [33:0] obs;
      int acc;
      repeat (3) @(negedge QCLK);
      obs = {cmd_ready, busy, done, phase, QSEL, QWRITE, QADDR, QDATAIN};
      tests++;
      if (obs !== {1'b1, 33'd0}) begin
         fails++; $display("FAIL reset_values got %h want %h", obs, {1'b1, 33'd0});
      end
      QRESET = 1'b1;
      run_cmd(3, 1, 40, acc);
      repeat (10) @(negedge QCLK);
      tests++;
      if (busy !== 1'b1) begin fails++; $display("FAIL busy_in_wait got %b want 1", busy); end
      #2 QRESET = 1'b0;
      #1 obs = {cmd_ready, busy, done, phase, QSEL, QWRITE, QADDR, QDATAIN};
      tests++;
      if (obs !== {1'b1, 33'd0}) begin
         fails++; $display("FAIL reset_mid_wait got %h want %h", obs, {1'b1, 33'd0});
      end
      @(negedge QCLK); QRESET = 1'b1;
      mphase = 0; clear_q();
      repeat (60) @(negedge QCLK);
      tests++;
      if (mon_q.size() != 0 || done_q.size() != 0) begin
         fails++; $display("FAIL reset_quiet got bus=%0d done=%0d want 0 0", mon_q.size(), done_q.size());
      end
      tests++;
      if (phase !== 6'd0 || cmd_ready !== 1'b1) begin
         fails++; $display("FAIL reset_after got phase=%0d ready=%b want 0 1", phase, cmd_ready);
      end
   endtask

   task automatic test_single_step();
      int acc, x, dexp;
      bit ok;
      tx_t got;
      for (int d = 1; d >= 0; d--) begin
         do_reset();
         run_cmd(1, d, 4, acc);
         x = build_steps(acc, 1, d, 4);
         dexp = add_end(x, 1'b1);
         wait_done(100, ok);
         tests++;
         if (!ok) begin fails++; $display("FAIL single_dir%0d timeout got no done want done", d); end
         tests++;
         if (mon_q.size() != exp_q.size()) begin
            fails++; $display("FAIL single_dir%0d count got %0d want %0d", d, mon_q.size(), exp_q.size());
         end
         foreach (exp_q[k]) begin
            got = (k < mon_q.size()) ? mon_q[k] : '0;
            tests++;
            if (got !== exp_q[k]) begin
               fails++;
               $display("FAIL single_dir%0d tx%0d got cyc=%0d a=%h d=%h want cyc=%0d a=%h d=%h", d, k,
                        got.cyc - 32'(acc), got.addr, got.data, exp_q[k].cyc - 32'(acc), exp_q[k].addr, exp_q[k].data);
            end
         end
         tests++;
         if (done_q.size() != 1 || done_q[0] != dexp) begin
            fails++; $display("FAIL single_dir%0d done got n=%0d cyc=%0d want cyc=%0d", d, done_q.size(),
                              (done_q.size() > 0) ? done_q[0] - acc : -1, dexp - acc);
         end
         tests++;
         if (phase !== 6'(mphase)) begin
            fails++; $display("FAIL single_dir%0d phase got %0d want %0d", d, phase, mphase);
         end
      end
   endtask

   task automatic test_host_contention();
      int acc, x, dexp;
      bit ok;
      tx_t h, got;
      clear_q();
      run_cmd(1, 1, 3, acc);
      while (cyc < acc + 4) @(negedge QCLK);
      host_sel = 1'b1; host_write = 1'b1; host_addr = 7'h10; host_data = 16'h1234;
      repeat (2) @(negedge QCLK);
      host_sel = 1'b0;
      x = build_steps(acc, 1, 1, 3);
      foreach (exp_q[k]) exp_q[k].cyc = exp_q[k].cyc + 32'd2;
      h.wr = 1'b1; h.addr = 7'h10; h.data = 16'h1234;
      h.cyc = 32'(acc + 6); exp_q.push_front(h);
      h.cyc = 32'(acc + 5); exp_q.push_front(h);
      dexp = add_end(x + 2, 1'b1);
      wait_done(100, ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL host_stall timeout got no done want done"); end
      tests++;
      if (mon_q.size() != exp_q.size()) begin
         fails++; $display("FAIL host_stall count got %0d want %0d", mon_q.size(), exp_q.size());
      end
      foreach (exp_q[k]) begin
         got = (k < mon_q.size()) ? mon_q[k] : '0;
         tests++;
         if (got !== exp_q[k]) begin
            fails++;
            $display("FAIL host_stall tx%0d got cyc=%0d w=%b a=%h d=%h want cyc=%0d w=%b a=%h d=%h", k,
                     got.cyc - 32'(acc), got.wr, got.addr, got.data,
                     exp_q[k].cyc - 32'(acc), exp_q[k].wr, exp_q[k].addr, exp_q[k].data);
         end
      end
      tests++;
      if (done_q.size() != 1 || done_q[0] != dexp) begin
         fails++; $display("FAIL host_stall done got cyc=%0d want %0d",
                           (done_q.size() > 0) ? done_q[0] - acc : -1, dexp - acc);
      end
   endtask

   task automatic test_abort();
      int cs[3][4] = '{'{100, 10, 29, 2}, '{5, 2, 7, 1}, '{5, 2, 3, 1}};
      int acc, x, dexp, base;
      bit ok;
      tx_t got;
      for (int c = 0; c < 3; c++) begin
         clear_q();
         run_cmd(cs[c][0], 1, cs[c][1], acc);
         while (cyc < acc + cs[c][2]) @(negedge QCLK);
         cmd_abort = 1'b1;
         @(negedge QCLK);
         cmd_abort = 1'b0;
         x = build_steps(acc, cs[c][3], 1, cs[c][1]);
         base = (x > acc + cs[c][2] + 1) ? x : acc + cs[c][2] + 1;
         dexp = add_end(base, 1'b1);
         wait_done(300, ok);
         tests++;
         if (!ok) begin fails++; $display("FAIL abort%0d timeout got no done want done", c); end
         tests++;
         if (mon_q.size() != exp_q.size()) begin
            fails++; $display("FAIL abort%0d count got %0d want %0d", c, mon_q.size(), exp_q.size());
         end
         foreach (exp_q[k]) begin
            got = (k < mon_q.size()) ? mon_q[k] : '0;
            tests++;
            if (got !== exp_q[k]) begin
               fails++;
               $display("FAIL abort%0d tx%0d got cyc=%0d a=%h d=%h want cyc=%0d a=%h d=%h", c, k,
                        got.cyc - 32'(acc), got.addr, got.data, exp_q[k].cyc - 32'(acc), exp_q[k].addr, exp_q[k].data);
            end
         end
         tests++;
         if (done_q.size() != 1 || done_q[0] != dexp) begin
            fails++; $display("FAIL abort%0d done got n=%0d cyc=%0d want cyc=%0d", c, done_q.size(),
                              (done_q.size() > 0) ? done_q[0] - acc : -1, dexp - acc);
         end
         tests++;
         if (phase !== 6'(mphase) || cmd_ready !== 1'b1) begin
            fails++; $display("FAIL abort%0d end got phase=%0d ready=%b want %0d 1", c, phase, cmd_ready, mphase);
         end
      end
   endtask

   task automatic test_random_cmds();
      int acc, x, dexp, n, per, dir;
      bit ok;
      tx_t got;
      for (int i = 0; i < 10; i++) begin
         clear_q();
         n   = (i == 0) ? 0 : int'($urandom_range(1, 4));
         per = (i == 1) ? 0 : int'($urandom_range(0, 5));
         dir = int'($urandom_range(0, 1));
         if (i == 2) cmd_abort = 1'b1;
         run_cmd(n, dir, per, acc);
         cmd_abort = 1'b0;
         x = build_steps(acc, n, dir, per);
         dexp = add_end(x, n > 0);
         wait_done(200, ok);
         tests++;
         if (!ok) begin fails++; $display("FAIL rand%0d timeout got no done want done", i); end
         tests++;
         if (mon_q.size() != exp_q.size()) begin
            fails++; $display("FAIL rand%0d count got %0d want %0d", i, mon_q.size(), exp_q.size());
         end
         foreach (exp_q[k]) begin
            got = (k < mon_q.size()) ? mon_q[k] : '0;
            tests++;
            if (got !== exp_q[k]) begin
               fails++;
               $display("FAIL rand%0d tx%0d got cyc=%0d a=%h d=%h want cyc=%0d a=%h d=%h", i, k,
                        got.cyc - 32'(acc), got.addr, got.data, exp_q[k].cyc - 32'(acc), exp_q[k].addr, exp_q[k].data);
            end
         end
         tests++;
         if (done_q.size() != 1 || done_q[0] != dexp) begin
            fails++; $display("FAIL rand%0d done got n=%0d cyc=%0d want cyc=%0d", i, done_q.size(),
                              (done_q.size() > 0) ? done_q[0] - acc : -1, dexp - acc);
         end
         tests++;
         if (phase !== 6'(mphase)) begin
            fails++; $display("FAIL rand%0d phase got %0d want %0d", i, phase, mphase);
         end
      end
      tests++;
      if (rdy_err != 0) begin fails++; $display("FAIL ready_with_done got %0d misses want 0", rdy_err); end
   endtask

   task automatic test_random_host();
      int acc, x, n, per, dir;
      bit ok;
      tx_t h, got, hexp[$], hq[$], fq[$];
      for (int i = 0; i < 4; i++) begin
         clear_q(); hexp.delete(); hq.delete(); fq.delete();
         n = int'($urandom_range(1, 4)); per = int'($urandom_range(0, 3)); dir = int'($urandom_range(0, 1));
         run_cmd(n, dir, per, acc);
         ok = 1'b0;
         for (int c = 0; c < 400; c++) begin
            if (done_q.size() > 0) begin ok = 1'b1; break; end
            host_sel = ($urandom_range(0, 2) == 0);
            if (host_sel) begin
               host_write = 1'($urandom_range(0, 1)); host_addr = 7'($urandom_range(0, 31));
               host_data = 16'($urandom);
               h.cyc = 32'(cyc + 1); h.wr = host_write; h.addr = host_addr; h.data = host_data;
               hexp.push_back(h);
            end
            @(negedge QCLK);
         end
         host_sel = 1'b0;
         repeat (4) @(negedge QCLK);
         x = build_steps(acc, n, dir, per);
         x = add_end(x, 1'b1);
         foreach (mon_q[k]) if (mon_q[k].addr >= 7'h20) fq.push_back(mon_q[k]); else hq.push_back(mon_q[k]);
         tests++;
         if (!ok) begin fails++; $display("FAIL host_rand%0d timeout got no done want done", i); end
         tests++;
         if (hq.size() != hexp.size() || fq.size() != exp_q.size()) begin
            fails++; $display("FAIL host_rand%0d count got host=%0d fsm=%0d want %0d %0d", i,
                              hq.size(), fq.size(), hexp.size(), exp_q.size());
         end
         foreach (hexp[k]) begin
            got = (k < hq.size()) ? hq[k] : '0;
            tests++;
            if (got !== hexp[k]) begin
               fails++; $display("FAIL host_rand%0d host%0d got cyc=%0d w=%b a=%h d=%h want cyc=%0d w=%b a=%h d=%h",
                                 i, k, got.cyc, got.wr, got.addr, got.data, hexp[k].cyc, hexp[k].wr, hexp[k].addr, hexp[k].data);
            end
         end
         foreach (exp_q[k]) begin
            got = (k < fq.size()) ? fq[k] : '0;
            tests++;
            if ({got.wr, got.addr, got.data} !== {exp_q[k].wr, exp_q[k].addr, exp_q[k].data}) begin
               fails++; $display("FAIL host_rand%0d fsm%0d got a=%h d=%h want a=%h d=%h",
                                 i, k, got.addr, got.data, exp_q[k].addr, exp_q[k].data);
            end
         end
         tests++;
         if (phase !== 6'(mphase)) begin
            fails++; $display("FAIL host_rand%0d phase got %0d want %0d", i, phase, mphase);
         end
      end
   endtask

   task automatic test_full_turn();
      int acc, x, dexp, errs;
      bit ok;
      tx_t got;
      do_reset();
      run_cmd(64, 1, 1, acc);
      x = build_steps(acc, 64, 1, 1);
      dexp = add_end(x, 1'b1);
      wait_done(600, ok);
      errs = 0;
      tests++;
      if (!ok) begin fails++; $display("FAIL full_turn timeout got no done want done"); end
      tests++;
      if (mon_q.size() != exp_q.size()) begin
         fails++; $display("FAIL full_turn count got %0d want %0d", mon_q.size(), exp_q.size());
      end
      foreach (exp_q[k]) begin
         got = (k < mon_q.size()) ? mon_q[k] : '0;
         tests++;
         if (got !== exp_q[k]) begin
            fails++;
            if (errs++ < 8)
               $display("FAIL full_turn tx%0d got cyc=%0d a=%h d=%h want cyc=%0d a=%h d=%h", k,
                        got.cyc - 32'(acc), got.addr, got.data, exp_q[k].cyc - 32'(acc), exp_q[k].addr, exp_q[k].data);
         end
      end
      tests++;
      if (done_q.size() != 1 || done_q[0] != dexp || phase !== 6'd0) begin
         fails++; $display("FAIL full_turn end got done=%0d phase=%0d want done=%0d phase=0",
                           (done_q.size() > 0) ? done_q[0] - acc : -1, phase, dexp - acc);
      end
   endtask

   initial begin
      test_reset();
      test_single_step();
      test_host_contention();
      test_abort();
      test_random_cmds();
      test_random_host();
      test_full_turn();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
